// File: rtl/detector_pulsacion_pkg.sv
// Shared definitions for the button press classifier: FSM state encoding
// and the counter sizing helper.
package detector_pulsacion_pkg;

  // State encoding shared with the debouncer bench so both decode state alike.
  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    PRESIONADO = 2'd1,
    MANTENIDO  = 2'd2
  } estado_t;

  // Counter width: enough bits to hold max(largo, repeticion) - 1, never below 1.
  function automatic int unsigned cnt_width(input int unsigned largo,
                                            input int unsigned repeticion);
    int unsigned mayor;
    int unsigned ancho;
    mayor = (largo > repeticion) ? largo : repeticion;
    ancho = $clog2(mayor);
    if (ancho < 32'd1) begin
      ancho = 32'd1;
    end else begin
      ancho = ancho;
    end
    return ancho;
  endfunction

endpackage

// File: rtl/detector_pulsacion.sv
// Turns a debounced button level into one-cycle strobes: short press on
// release before the long threshold, long press when the threshold is reached
// while held, and auto-repeat ticks while the long press continues.
module detector_pulsacion
  import detector_pulsacion_pkg::*;
#(
  parameter int unsigned LARGO      = 32'd50000000,
  parameter int unsigned REPETICION = 32'd10000000,
  parameter bit          REP_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic presionado,
  output logic pulso_corto,
  output logic pulso_largo,
  output logic pulso_rep
);

  localparam int unsigned   CW        = cnt_width(LARGO, REPETICION);
  localparam logic [CW-1:0] LARGO_FIN = CW'(LARGO - 32'd1);
  localparam logic [CW-1:0] REP_FIN   = CW'(REPETICION - 32'd1);
  localparam logic [CW-1:0] CNT_CERO  = CW'(32'd0);
  localparam logic [CW-1:0] CNT_UNO   = CW'(32'd1);

  estado_t       estado_r;
  logic [CW-1:0] cnt_r;

  // Classification FSM and hold counter; strobes default low every cycle and
  // a release always wins over a threshold hit in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_r    <= REPOSO;
      cnt_r       <= CNT_CERO;
      presionado  <= 1'b0;
      pulso_corto <= 1'b0;
      pulso_largo <= 1'b0;
      pulso_rep   <= 1'b0;
    end else begin
      pulso_corto <= 1'b0;
      pulso_largo <= 1'b0;
      pulso_rep   <= 1'b0;
      case (estado_r)
        REPOSO: begin
          if (btn) begin
            estado_r   <= PRESIONADO;
            cnt_r      <= CNT_CERO;
            presionado <= 1'b1;
          end else begin
            estado_r   <= REPOSO;
            presionado <= 1'b0;
          end
        end
        PRESIONADO: begin
          if (!btn) begin
            estado_r    <= REPOSO;
            cnt_r       <= CNT_CERO;
            presionado  <= 1'b0;
            pulso_corto <= 1'b1;
          end else if (cnt_r == LARGO_FIN) begin
            estado_r    <= MANTENIDO;
            cnt_r       <= CNT_CERO;
            presionado  <= 1'b1;
            pulso_largo <= 1'b1;
          end else begin
            estado_r   <= PRESIONADO;
            cnt_r      <= cnt_r + CNT_UNO;
            presionado <= 1'b1;
          end
        end
        MANTENIDO: begin
          if (!btn) begin
            // No strobe on release after a long press.
            estado_r   <= REPOSO;
            cnt_r      <= CNT_CERO;
            presionado <= 1'b0;
          end else if (cnt_r == REP_FIN) begin
            // Reload keeps the counter bounded even with repeat disabled.
            estado_r   <= MANTENIDO;
            cnt_r      <= CNT_CERO;
            presionado <= 1'b1;
            pulso_rep  <= REP_EN;
          end else begin
            estado_r   <= MANTENIDO;
            cnt_r      <= cnt_r + CNT_UNO;
            presionado <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: recover to idle with outputs cleared.
          estado_r   <= REPOSO;
          cnt_r      <= CNT_CERO;
          presionado <= 1'b0;
        end
      endcase
    end
  end

endmodule
